mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single-port unified instruction/data memory between the CPU datapath (requester C: fetch, load, store) and a debug/DMA loader (requester D). Latches the winning request, drives the memory address, write-enable and write-data lines, waits out the read latency, and returns read data with a one-cycle acknowledge. It sits between the CPU's memory-address mux and the memory, so the control unit stalls on `c_ack` rather than assuming a fixed memory cycle.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles; legal range 1–4.
- `LOCK_MAX`, default 8: maximum consecutive D transactions under `d_lock` while C is waiting.
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `c_req`, `c_wr` in 1 each: CPU request and write select (1 = write).
- `c_addr`, `c_wdata` in 32 each: CPU byte address and store data.
- `c_rdata` out 32: CPU read data.
- `c_ack` out 1: CPU completion pulse.
- `d_req`, `d_wr`, `d_lock` in 1 each: debug request, write select, and hold-bus request.
- `d_addr`, `d_wdata` in 32 each: debug byte address and store data.
- `d_rdata` out 32: debug read data.
- `d_ack` out 1: debug completion pulse.
- `mem_addr`, `mem_wdata` out 32 each: to the memory.
- `mem_wr` out 1: memory write enable.
- `mem_rdata` in 32: from the memory.
- `owner` out 1: current or last grant (0 = C, 1 = D).
- `arb_state` out 2: FSM state, for waveform and debug.

## Operation
- FSM states:
  - IDLE: no transaction in progress. Requests are sampled here only.
  - ISSUE: exactly 1 cycle; `mem_wr` may be high only in this state.
  - WAIT: RD_LAT cycles.
  - ACK: 1 cycle.
- IDLE transitions:
  - no request → stay in IDLE.
  - any request → ISSUE, latching the winner's `wr`/`addr`/`wdata` into internal registers.
- ISSUE → WAIT. WAIT → ACK when its counter reaches RD_LAT−1. ACK → IDLE.
- `mem_addr`, `mem_wdata` and `mem_wr` are driven from the latched registers during ISSUE and WAIT.
- `mem_addr` is held through WAIT. `mem_wr` is 0 outside ISSUE.
- `mem_rdata` is captured into the owner's `rdata` register on the last WAIT cycle.
  - The captured value is presented on the ACK cycle and held until that requester's next ack.
  - Writes follow the same path; their `rdata` register is not updated.
- Arbitration, evaluated in IDLE:
  - Only one requester active → grant it.
  - Both active and a lock is in force → grant D. A lock is in force when `owner`=1, `d_lock`=1 and `hold_cnt` < LOCK_MAX.
  - Both active otherwise → round-robin: grant the requester that is not `owner`.
- `hold_cnt` (width $clog2(LOCK_MAX+1)):
  - increments on each D grant, saturating at LOCK_MAX;
  - clears on each C grant and whenever `d_lock`=0 at a D grant.
  - While only D requests, it keeps being granted regardless of `hold_cnt`.
- Requester contract:
  - hold `req`, `wr`, `addr` and `wdata` stable from assertion until ack;
  - for a single transaction, deassert `req` in the cycle after ack;
  - `req` still high in IDLE starts a new transaction.
- `c_ack` and `d_ack` are never high in the same cycle.

## Timing
- Request high in IDLE at cycle T: ISSUE at T+1, WAIT at T+2 … T+1+RD_LAT, ACK at T+2+RD_LAT. With the default RD_LAT=1, ack arrives at T+3.
- Back-to-back transactions from one requester issue every RD_LAT+3 cycles (one IDLE bubble between them).
- Reset values: state IDLE, `owner`=1 (so C wins the first tie), `hold_cnt`=0. All other outputs and internal latches are 0.
- Reset asserted mid-transaction: at the next edge the block enters IDLE and `mem_wr` drops. The transaction is abandoned with no ack, and neither `rdata` register is updated.
- A request deasserted before ack, in violation of the contract, still completes. The latched values are used and the ack is still issued.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t`, a 2-bit enum (IDLE, ISSUE, WAIT, ACK);
  - `owner_t` constants OWN_C=0 and OWN_D=1.
- One sub-module is natural: `arb_hold_counter`, a saturating counter with inc/clr inputs and an `at_max` output, used for `hold_cnt`.
- The grant logic, WAIT counter and latches stay in the top module.

## Test plan
- Single C read at 0x40 with memory returning 0xDEADBEEF, RD_LAT=1 → `mem_addr`=0x40 at T+1 and T+2, `c_ack` high at T+3 only, `c_rdata`=0xDEADBEEF; `d_ack` stays 0.
- D write of 0x12345678 to 0x100 → `mem_wr` high exactly at T+1 with `mem_wdata`=0x12345678; `d_ack` at T+3; `d_rdata` unchanged.
- C and D requesting continuously, `d_lock`=0 → grants alternate C, D, C, D; each ack is 4 cycles apart; the first grant goes to C.
- C and D requesting continuously, `d_lock`=1, LOCK_MAX=8 → after the first C grant there are 8 consecutive D grants, then C, then D again.
- RD_LAT=3 with a C read → `c_ack` at T+5; memory data is captured from the T+4 cycle.
- Reset asserted at T+2 of a D read → IDLE at T+3, no `d_ack`, `d_rdata`=0, `mem_wr`=0; a C request at T+4 is acked at T+7.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM encoding, owner ids
// and the latched request record.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
// The arbiter takes the slave side; requesters plus memory take master.
interface mem_port_arbiter_if;
    logic        c_req;
    logic        c_wr;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_ack;

    logic        d_req;
    logic        d_wr;
    logic        d_lock;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic        owner;
    logic [1:0]  arb_state;

    modport slave (
        input  c_req, c_wr, c_addr, c_wdata,
        input  d_req, d_wr, d_lock, d_addr, d_wdata,
        input  mem_rdata,
        output c_rdata, c_ack, d_rdata, d_ack,
        output mem_addr, mem_wdata, mem_wr,
        output owner, arb_state
    );

    modport master (
        output c_req, c_wr, c_addr, c_wdata,
        output d_req, d_wr, d_lock, d_addr, d_wdata,
        output mem_rdata,
        input  c_rdata, c_ack, d_rdata, d_ack,
        input  mem_addr, mem_wdata, mem_wr,
        input  owner, arb_state
    );
endinterface

// File: rtl/mem_port_arbiter_hold.sv
// Saturating counter tracking consecutive locked D grants; clear wins over inc.
module arb_hold_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == W'(MAX));
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !at_max)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU (C) and a debug/DMA loader (D):
// IDLE -> ISSUE -> WAIT x RD_LAT -> ACK, with round-robin plus D bus lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int         HCW       = $clog2(LOCK_MAX + 1);
    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_ISSUE   = 2'(ISSUE);
    localparam logic [1:0] S_WAIT    = 2'(WAIT);
    localparam logic [1:0] S_ACK     = 2'(ACK);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [1:0]     state_q, state_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic           owner_q, owner_d;
    mem_req_t       lat_q, lat_d;
    logic [31:0]    c_rdata_q, c_rdata_d;
    logic [31:0]    d_rdata_q, d_rdata_d;

    logic [HCW-1:0] hold_cnt;
    logic           hold_at_max;
    logic           hold_inc, hold_clr;
    logic           any_req, lock_on, grant_d, grant;
    mem_req_t       c_pkt, d_pkt;

    // Lock only holds D on the bus while it already owns it and has budget left.
    always_comb begin
        any_req  = bus.c_req | bus.d_req;
        lock_on  = (owner_q == OWN_D) & bus.d_lock & (hold_cnt < HCW'(LOCK_MAX));
        grant_d  = bus.d_req & (~bus.c_req | lock_on | (owner_q == OWN_C));
        grant    = (state_q == S_IDLE) & any_req;
        hold_inc = grant & grant_d & bus.d_lock & ~hold_at_max;
        hold_clr = grant & (~grant_d | ~bus.d_lock);
        c_pkt    = '{wr: bus.c_wr, addr: bus.c_addr, wdata: bus.c_wdata};
        d_pkt    = '{wr: bus.d_wr, addr: bus.d_addr, wdata: bus.d_wdata};
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ISSUE;
                    owner_d = grant_d;
                    lat_d   = grant_d ? d_pkt : c_pkt;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_ACK;
                    if (!lat_q.wr) begin
                        if (owner_q == OWN_D)
                            d_rdata_d = bus.mem_rdata;
                        else
                            c_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            owner_q   <= OWN_D;
            lat_q     <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            owner_q   <= owner_d;
            lat_q     <= lat_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    arb_hold_counter #(.MAX(LOCK_MAX), .W(HCW)) u_hold (
        .clock  (clock),
        .reset  (reset),
        .inc    (hold_inc),
        .clr    (hold_clr),
        .cnt    (hold_cnt),
        .at_max (hold_at_max)
    );

    logic drive_mem;
    assign drive_mem     = (state_q == S_ISSUE) | (state_q == S_WAIT);
    assign bus.mem_addr  = drive_mem ? lat_q.addr  : '0;
    assign bus.mem_wdata = drive_mem ? lat_q.wdata : '0;
    assign bus.mem_wr    = (state_q == S_ISSUE) & lat_q.wr;
    assign bus.c_ack     = (state_q == S_ACK) & (owner_q == OWN_C);
    assign bus.d_ack     = (state_q == S_ACK) & (owner_q == OWN_D);
    assign bus.c_rdata   = c_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.owner     = owner_q;
    assign bus.arb_state = state_q;

endmodule
